// File: rtl/fft_sequencer_if.sv
// Bus between the FFT sequencer and its neighbours: the sample source,
// the bin consumer, the address generator and the ping-pong sample RAMs.
//
// Handshake rule (both directions): a transfer happens on a rising clock
// edge where valid and ready are both high. The source holds its data
// while valid is high and ready is low. Valid never waits on ready.
// In this block sample_ready and out_valid depend only on the phase,
// so neither side has a combinational path through the other.
interface fft_sequencer_if;
    // Sample source -> sequencer
    logic       sample_valid;
    logic       sample_ready;
    // Sequencer -> bin consumer
    logic       out_ready;
    logic       out_valid;
    logic       out_last;
    // Phase flags and indices toward the address generator
    logic       load;
    logic       processing;
    logic       done;
    logic [5:0] fft_level;
    logic [5:0] butterfly_iter;
    logic [5:0] load_address;
    logic [5:0] out_address;
    // Ping-pong bank control
    logic       rd_bank;
    logic       we_0;
    logic       we_1;
    // Current FSM state, for observation only (0 = LOAD, 1 = PROC, 2 = OUT)
    logic [1:0] dbg_state;

    modport master (
        input  sample_valid, out_ready,
        output sample_ready, out_valid, out_last,
        output load, processing, done,
        output fft_level, butterfly_iter, load_address, out_address,
        output rd_bank, we_0, we_1, dbg_state
    );

    modport slave (
        output sample_valid, out_ready,
        input  sample_ready, out_valid, out_last,
        input  load, processing, done,
        input  fft_level, butterfly_iter, load_address, out_address,
        input  rd_bank, we_0, we_1, dbg_state
    );
endinterface

// File: rtl/fft_sequencer.sv
// Frame sequencer for the 64-point radix-2 FFT core.
// Runs LOAD (64 accepted samples) -> PROC (6 levels x 32 butterflies)
// -> OUT (64 accepted bins) back to back with no idle state. Everything
// except the FSM state and the four index counters is a combinational
// decode of those registers and the two handshake inputs.
module fft_sequencer #(
    parameter int LOG2N = 6
) (
    input  logic            clk,
    input  logic            reset,
    fft_sequencer_if.master bus
);

    // The index ports are fixed at 6 bits, so only LOG2N = 6 is meaningful.
    localparam int          N        = 1 << LOG2N;
    localparam logic [5:0]  LAST_IDX = 6'(N - 1);
    localparam logic [5:0]  LAST_BF  = 6'((N / 2) - 1);
    localparam logic [5:0]  LAST_LVL = 6'(LOG2N - 1);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_PROC = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] load_addr_q, load_addr_d;
    logic [5:0] level_q, level_d;
    logic [5:0] iter_q, iter_d;
    logic [5:0] out_addr_q, out_addr_d;

    logic       sample_ready;
    logic       out_valid;
    logic       out_last;
    logic       load;
    logic       processing;
    logic       done;
    logic       rd_bank;
    logic       we_0;
    logic       we_1;

    // Registered state; reset aborts any frame and restarts in LOAD.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_LOAD;
            load_addr_q <= '0;
            level_q     <= '0;
            iter_q      <= '0;
            out_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            load_addr_q <= load_addr_d;
            level_q     <= level_d;
            iter_q      <= iter_d;
            out_addr_q  <= out_addr_d;
        end
    end

    // Next-state and output decode; counters hold unless their phase moves them.
    always_comb begin
        state_d      = state_q;
        load_addr_d  = load_addr_q;
        level_d      = level_q;
        iter_d       = iter_q;
        out_addr_d   = out_addr_q;
        sample_ready = 1'b0;
        out_valid    = 1'b0;
        out_last     = 1'b0;
        load         = 1'b0;
        processing   = 1'b0;
        done         = 1'b0;
        rd_bank      = 1'b0;
        we_0         = 1'b0;
        we_1         = 1'b0;

        case (state_q)
            S_LOAD: begin
                load         = 1'b1;
                sample_ready = 1'b1;
                // Samples always land in bank 0 so level 0 reads bank 0.
                we_0         = bus.sample_valid;
                if (bus.sample_valid) begin
                    if (load_addr_q == LAST_IDX) begin
                        load_addr_d = '0;
                        state_d     = S_PROC;
                    end else begin
                        load_addr_d = load_addr_q + 6'd1;
                    end
                end
            end

            S_PROC: begin
                processing = 1'b1;
                // Even levels read bank 0 and write bank 1, odd levels the
                // reverse; with six levels the spectrum ends in bank 0.
                rd_bank    = level_q[0];
                we_0       = level_q[0];
                we_1       = ~level_q[0];
                if (iter_q == LAST_BF) begin
                    iter_d = '0;
                    if (level_q == LAST_LVL) begin
                        level_d = '0;
                        state_d = S_OUT;
                    end else begin
                        level_d = level_q + 6'd1;
                    end
                end else begin
                    iter_d = iter_q + 6'd1;
                end
            end

            S_OUT: begin
                done      = 1'b1;
                out_valid = 1'b1;
                out_last  = (out_addr_q == LAST_IDX);
                if (bus.out_ready) begin
                    if (out_addr_q == LAST_IDX) begin
                        out_addr_d = '0;
                        state_d    = S_LOAD;
                    end else begin
                        out_addr_d = out_addr_q + 6'd1;
                    end
                end
            end

            default: begin
                // Unreachable encoding: fall back to a clean LOAD start.
                state_d     = S_LOAD;
                load_addr_d = '0;
                level_d     = '0;
                iter_d      = '0;
                out_addr_d  = '0;
            end
        endcase
    end

    assign bus.sample_ready   = sample_ready;
    assign bus.out_valid      = out_valid;
    assign bus.out_last       = out_last;
    assign bus.load           = load;
    assign bus.processing     = processing;
    assign bus.done           = done;
    assign bus.fft_level      = level_q;
    assign bus.butterfly_iter = iter_q;
    assign bus.load_address   = load_addr_q;
    assign bus.out_address    = out_addr_q;
    assign bus.rd_bank        = rd_bank;
    assign bus.we_0           = we_0;
    assign bus.we_1           = we_1;
    assign bus.dbg_state      = state_q;

endmodule

// File: tb/tb_fft_sequencer.sv
// Bench for fft_sequencer: phase/index model checked every cycle, a bin
// order scoreboard for the output phase, and directed phase-length checks.
module tb_fft_sequencer;

    logic clk = 1'b0;
    logic reset;

    fft_sequencer_if bus ();

    fft_sequencer #(.LOG2N(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phase plus a single progress count k inside that phase:
    // LOAD: k accepted samples; PROC: k cycles elapsed (level = k/32,
    // butterfly = k%32); OUT: k accepted bins.
    typedef enum int {PH_LOAD, PH_PROC, PH_OUT} ph_t;
    ph_t m_ph;
    int  m_k;
    bit  m_valid = 1'b0;

    logic [5:0] exp_q[$];

    always @(posedge clk) begin
        if (reset) begin
            m_ph    <= PH_LOAD;
            m_k     <= 0;
            m_valid <= 1'b1;
            exp_q.delete();
        end else if (m_valid) begin
            case (m_ph)
                PH_LOAD: if (bus.sample_valid) begin
                    if (m_k + 1 == 64) begin m_ph <= PH_PROC; m_k <= 0; end
                    else m_k <= m_k + 1;
                end
                PH_PROC: begin
                    if (m_k + 1 == 192) begin
                        m_ph <= PH_OUT;
                        m_k  <= 0;
                        for (int b = 0; b < 64; b++) exp_q.push_back(6'(b));
                    end else m_k <= m_k + 1;
                end
                default: if (bus.out_ready) begin
                    if (m_k + 1 == 64) begin m_ph <= PH_LOAD; m_k <= 0; end
                    else m_k <= m_k + 1;
                end
            endcase
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            automatic bit is_l = (m_ph == PH_LOAD);
            automatic bit is_p = (m_ph == PH_PROC);
            automatic bit is_o = (m_ph == PH_OUT);
            automatic int lvl  = is_p ? m_k / 32 : 0;
            automatic int bf   = is_p ? m_k % 32 : 0;
            automatic bit par  = lvl[0];
            chk("load",           bus.load,           is_l);
            chk("processing",     bus.processing,     is_p);
            chk("done",           bus.done,           is_o);
            chk("onehot",         $onehot({bus.load, bus.processing, bus.done}), 1);
            chk("sample_ready",   bus.sample_ready,   is_l);
            chk("out_valid",      bus.out_valid,      is_o);
            chk("out_last",       bus.out_last,       is_o && m_k == 63);
            chk("fft_level",      bus.fft_level,      lvl);
            chk("butterfly_iter", bus.butterfly_iter, bf);
            chk("load_address",   bus.load_address,   is_l ? m_k : 0);
            chk("out_address",    bus.out_address,    is_o ? m_k : 0);
            chk("rd_bank",        bus.rd_bank,        is_p && par);
            chk("we_0",           bus.we_0,           (is_l && bus.sample_valid) || (is_p && par));
            chk("we_1",           bus.we_1,           is_p && !par);
            if (is_o && bus.out_ready) begin
                if (exp_q.size() == 0) chk("bin_queue_empty", 1, 0);
                else chk("bin_order", bus.out_address, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int accepts;

        reset = 1'b1;
        bus.sample_valid = 1'b0;
        bus.out_ready    = 1'b0;
        repeat (2) step();
        reset = 1'b0;

        // Idle load phase: nothing accepted.
        repeat (10) step();
        chk("idle_load", bus.load, 1);
        chk("idle_ready", bus.sample_ready, 1);
        chk("idle_addr", bus.load_address, 0);
        chk("idle_we0", bus.we_0, 0);

        // 64 samples with random gaps.
        accepts = 0;
        n = 0;
        while (accepts < 64 && n < 2000) begin
            bus.sample_valid = 1'($urandom_range(0, 1));
            if (bus.sample_valid && bus.sample_ready) accepts++;
            step();
            n++;
        end
        bus.sample_valid = 1'b0;
        chk("load_accepts", accepts, 64);
        chk("proc_rise", bus.processing, 1);

        // Butterfly sweep length.
        n = 0;
        while (bus.processing && n < 400) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        chk("proc_len", n, 192);
        chk("out_entry", bus.done, 1);

        // Output with out_ready alternating, starting low.
        bus.out_ready = 1'b0;
        n = 0;
        while (bus.done && n < 400) begin
            step();
            bus.out_ready = ~bus.out_ready;
            n++;
        end
        bus.out_ready = 1'b0;
        chk("out_len", n, 128);
        chk("load_after_out", bus.load, 1);

        // Reset in the middle of level 3.
        bus.sample_valid = 1'b1;
        n = 0;
        while (!bus.processing && n < 200) begin step(); n++; end
        bus.sample_valid = 1'b0;
        chk("load_fast", n, 64);
        n = 0;
        while (!(bus.fft_level == 6'd3 && bus.butterfly_iter == 6'd17) && n < 400) begin
            step();
            n++;
        end
        chk("reach_l3_i17", n, 3 * 32 + 17);
        chk("pre_reset_we1", bus.we_1, 0);
        chk("pre_reset_we0", bus.we_0, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_load", bus.load, 1);
        chk("rst_level", bus.fft_level, 0);
        chk("rst_iter", bus.butterfly_iter, 0);
        chk("rst_we1", bus.we_1, 0);
        chk("rst_load_addr", bus.load_address, 0);

        // Two back-to-back frames at full rate.
        bus.sample_valid = 1'b1;
        bus.out_ready    = 1'b1;
        for (int f = 0; f < 2; f++) begin
            n = 0;
            do begin
                step();
                n++;
            end while (!(bus.load && bus.load_address == 6'd0) && n < 1000);
            chk("frame_period", n, 320);
        end

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            bus.sample_valid = 1'($urandom_range(0, 1));
            bus.out_ready    = 1'($urandom_range(0, 1));
            reset            = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_sequencer.md
# fft_sequencer

Top-level sequencer for the 64-point radix-2 FFT core. It sits directly upstream of the address generator and drives its `load` / `processing` / `done` phase flags and its `fft_level`, `butterfly_iter`, `load_address` and `out_address` indices. It also produces the two bank write enables for the ping-pong sample RAMs and the ready/valid handshakes toward the sample source and the bin consumer. Sample RAMs are read combinationally, so each butterfly reads one bank and writes the other in the same cycle.

## Interface
Parameters:
- `LOG2N`, default 6: log2 of FFT size. Only 6 is supported; the index ports are 6 bits wide.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sample_valid`  in  1  upstream sample present on the data bus.
- `sample_ready`  out  1  sequencer accepts a sample this cycle.
- `out_ready`  in  1  downstream consumes the current bin.
- `out_valid`  out  1  bin at `out_address` is presented.
- `out_last`  out  1  marks bin 63.
- `load`  out  1  load phase flag to the address generator.
- `processing`  out  1  butterfly phase flag to the address generator.
- `done`  out  1  output phase flag to the address generator.
- `fft_level`  out  6  current stage, 0..5.
- `butterfly_iter`  out  6  butterfly index within the stage, 0..31.
- `load_address`  out  6  natural-order index of the next sample (the address generator bit-reverses it).
- `out_address`  out  6  index of the bin being output.
- `rd_bank`  out  1  bank read by the butterfly: 0 = bank 0, 1 = bank 1.
- `we_0`  out  1  write enable, bank 0.
- `we_1`  out  1  write enable, bank 1.

## Operation
- FSM states: LOAD, PROC, OUT. Reset enters LOAD. There is no idle state; the sequencer runs frames back to back.
- Registered state: FSM state, `load_address`, `fft_level`, `butterfly_iter`, `out_address`.
- All other outputs are combinational decodes of the registered state and the inputs.

LOAD:
- `load` = 1, `sample_ready` = 1, `we_0` = `sample_valid`, `we_1` = 0.
- On accept (`sample_valid` = 1): `load_address` increments.
- Accept at `load_address` = 63: `load_address` wraps to 0 and the FSM moves to PROC.
- No accept: all state holds.

PROC:
- `processing` = 1, `sample_ready` = 0.
- `butterfly_iter` increments every cycle; no stalls.
- At `butterfly_iter` = 31: it wraps to 0 and `fft_level` increments.
- At `fft_level` = 5 with `butterfly_iter` = 31: both counters clear and the FSM moves to OUT.
- `rd_bank` = `fft_level[0]`.
- `we_1` = ~`fft_level[0]`, `we_0` = `fft_level[0]`, so even levels write bank 1 and odd levels write bank 0.
- Final spectrum therefore lands in bank 0.

OUT:
- `done` = 1, `out_valid` = 1, `rd_bank` = 0, `we_0` = `we_1` = 0.
- `out_address` advances on `out_valid` & `out_ready`.
- `out_last` = (`out_address` == 63).
- Accept at 63: `out_address` wraps to 0 and the FSM moves to LOAD.
- `out_ready` = 0: `out_address` holds.

Flags and width rules:
- `load`, `processing` and `done` are mutually exclusive, one-hot, and exactly one is high at all times.
- Counters wrap modulo their ranges; `butterfly_iter[5]` is always 0 and `fft_level` never exceeds 5.
- Outside their own phase, `fft_level`, `butterfly_iter`, `load_address` and `out_address` are held at 0.

## Timing
- Reset values, in the cycle after `reset` is sampled high:
  - state = LOAD;
  - `load` = 1, `sample_ready` = 1;
  - `we_0` = `sample_valid`;
  - all counters = 0;
  - `processing`, `done`, `out_valid`, `out_last`, `we_1`, `rd_bank` = 0.
- Reset mid-frame, in any state, aborts the frame and reaches the same values in the next cycle. Bank contents are not cleared.
- Load phase takes 64 accepting cycles; stalls on `sample_valid` = 0 are unbounded.
- PROC is exactly 192 cycles (6 × 32), starting in the cycle after the 64th accept.
- First OUT cycle follows the last PROC cycle (level 5, iteration 31) with no bubble.
- Output phase takes 64 accepting cycles. The first LOAD cycle of the next frame directly follows the accept of bin 63.
- Minimum frame period is 320 cycles.
- `reset` takes priority over every handshake in the same cycle.

## Test plan
- Reset, hold `sample_valid` = 0 for 10 cycles -> `load` = 1, `sample_ready` = 1, `load_address` = 0, `we_0` = 0 throughout.
- Stream 64 samples with random `sample_valid` gaps -> `load_address` steps 0..63, only on accept; `processing` rises the cycle after the 64th accept.
- PROC sweep -> exactly 192 cycles; (`fft_level`, `butterfly_iter`) follows (0,0)..(0,31),(1,0)..(5,31); `we_1` is high for levels 0/2/4 and `we_0` for 1/3/5; `rd_bank` equals the level parity.
- OUT with `out_ready` toggled on alternate cycles -> `out_address` holds when `out_ready` = 0; `out_last` is high only at 63; `load` rises the cycle after bin 63 is accepted.
- Assert `reset` at PROC level 3, iteration 17 -> next cycle state = LOAD with all counters 0 and `we_1` = 0.
- Run two back-to-back frames with `sample_valid` = `out_ready` = 1 -> period is exactly 320 cycles, and the phase flags are one-hot every cycle.
